// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU codes,
// sequencer states and decoded instruction classes.
package cpu_defs;

   localparam logic [4:0] OPC_LD   = 5'b00000;
   localparam logic [4:0] OPC_LDI  = 5'b00001;
   localparam logic [4:0] OPC_ST   = 5'b00010;
   localparam logic [4:0] OPC_ADD  = 5'b00011;
   localparam logic [4:0] OPC_SUB  = 5'b00100;
   localparam logic [4:0] OPC_AND  = 5'b01001;
   localparam logic [4:0] OPC_OR   = 5'b01010;
   localparam logic [4:0] OPC_ADDI = 5'b01011;
   localparam logic [4:0] OPC_ANDI = 5'b01100;
   localparam logic [4:0] OPC_ORI  = 5'b01101;
   localparam logic [4:0] OPC_BR   = 5'b10010;
   localparam logic [4:0] OPC_JR   = 5'b10011;
   localparam logic [4:0] OPC_IN   = 5'b10101;
   localparam logic [4:0] OPC_OUT  = 5'b10110;
   localparam logic [4:0] OPC_NOP  = 5'b11001;
   localparam logic [4:0] OPC_HALT = 5'b11010;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SHR = 4'd4,
      ALU_SHL = 4'd5,
      ALU_ROR = 4'd6,
      ALU_ROL = 4'd7
   } alu_op_t;

   typedef enum logic [3:0] {
      RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
   } state_t;

   typedef enum logic [3:0] {
      CLS_RALU, CLS_IALU, CLS_LD, CLS_LDI, CLS_ST, CLS_BR,
      CLS_JR, CLS_IN, CLS_OUT, CLS_NOP, CLS_HALT
   } iclass_t;

endpackage

// File: rtl/control_sequencer_opcode_decode.sv
// Maps the opcode field to an instruction class and its ALU operation.
module opcode_decode
   import cpu_defs::*;
#(
   parameter int unsigned OPC_W           = 5,
   parameter int unsigned HALT_ON_ILLEGAL = 0
) (
   input  logic [OPC_W-1:0] i_opcode,
   output iclass_t          o_iclass,
   output alu_op_t          o_alu_op
);

   // Classify the opcode; unsupported encodings fall back to nop or halt.
   always_comb begin
      o_iclass = (HALT_ON_ILLEGAL != 0) ? CLS_HALT : CLS_NOP;
      o_alu_op = ALU_ADD;
      case (i_opcode)
         OPC_W'(OPC_ADD):  o_iclass = CLS_RALU;
         OPC_W'(OPC_SUB):  begin o_iclass = CLS_RALU; o_alu_op = ALU_SUB; end
         OPC_W'(OPC_AND):  begin o_iclass = CLS_RALU; o_alu_op = ALU_AND; end
         OPC_W'(OPC_OR):   begin o_iclass = CLS_RALU; o_alu_op = ALU_OR;  end
         OPC_W'(OPC_ADDI): o_iclass = CLS_IALU;
         OPC_W'(OPC_ANDI): begin o_iclass = CLS_IALU; o_alu_op = ALU_AND; end
         OPC_W'(OPC_ORI):  begin o_iclass = CLS_IALU; o_alu_op = ALU_OR;  end
         OPC_W'(OPC_LD):   o_iclass = CLS_LD;
         OPC_W'(OPC_LDI):  o_iclass = CLS_LDI;
         OPC_W'(OPC_ST):   o_iclass = CLS_ST;
         OPC_W'(OPC_BR):   o_iclass = CLS_BR;
         OPC_W'(OPC_JR):   o_iclass = CLS_JR;
         OPC_W'(OPC_IN):   o_iclass = CLS_IN;
         OPC_W'(OPC_OUT):  o_iclass = CLS_OUT;
         OPC_W'(OPC_NOP):  o_iclass = CLS_NOP;
         OPC_W'(OPC_HALT): o_iclass = CLS_HALT;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, per-class execute T3-T7, HALT.
module control_sequencer
   import cpu_defs::*;
#(
   parameter int unsigned HALT_ON_ILLEGAL = 0,
   parameter int unsigned OPC_W           = 5
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   output logic        PCout,
   output logic        Zhiout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        InPortout,
   output logic        BAout,
   output logic        Cout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        OutPortin,
   output logic        CONIn,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic [3:0]  alu_op,
   output logic        Run,
   output logic        instr_done
);

   state_t  r_state;
   iclass_t w_iclass;
   alu_op_t w_alu_op;
   state_t  w_last_state;
   logic    w_done;
   logic    w_unused_ir;

   assign w_unused_ir = ^IR[31-OPC_W:0];

   opcode_decode #(
      .OPC_W           (OPC_W),
      .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
   ) u_decode (
      .i_opcode (IR[31 -: OPC_W]),
      .o_iclass (w_iclass),
      .o_alu_op (w_alu_op)
   );

   // Final execute state of the current instruction class.
   always_comb begin
      w_last_state = T3;
      case (w_iclass)
         CLS_RALU, CLS_IALU, CLS_LDI: w_last_state = T5;
         CLS_BR:                      w_last_state = T6;
         CLS_LD, CLS_ST:              w_last_state = T7;
         default:                     w_last_state = T3;
      endcase
   end

   assign w_done = (r_state == w_last_state) && (w_iclass != CLS_HALT);

   // Sequencer state register; Clear overrides every transition.
   always_ff @(posedge Clock) begin
      if (Clear) begin
         r_state <= RST;
      end else begin
         case (r_state)
            RST:  r_state <= T0;
            T0:   r_state <= T1;
            T1:   r_state <= T2;
            T2:   r_state <= T3;
            T3:   r_state <= (w_iclass == CLS_HALT) ? HALT : (w_done ? T0 : T4);
            T4:   r_state <= w_done ? T0 : T5;
            T5:   r_state <= w_done ? T0 : T6;
            T6:   r_state <= w_done ? T0 : T7;
            T7:   r_state <= T0;
            HALT: r_state <= HALT;
            default: r_state <= RST;
         endcase
      end
   end

   // Control outputs decoded from the current state and opcode class.
   always_comb begin
      {PCout, Zhiout, Zlowout, MDRout, InPortout, BAout, Cout} = '0;
      {MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn}   = '0;
      {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout}           = '0;
      alu_op     = ALU_ADD;
      Run        = (r_state != HALT);
      instr_done = w_done;
      case (r_state)
         T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
         T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         T2: begin MDRout = 1'b1; IRin = 1'b1; end
         T3: begin
            case (w_iclass)
               CLS_RALU, CLS_IALU:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               CLS_LD, CLS_LDI, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               CLS_BR:  begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
               CLS_JR:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               CLS_IN:  begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_OUT: begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
               default: ;
            endcase
         end
         T4: begin
            case (w_iclass)
               CLS_RALU: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_alu_op; end
               CLS_IALU: begin Cout = 1'b1; Zin = 1'b1; alu_op = w_alu_op; end
               CLS_LD, CLS_LDI, CLS_ST: begin Cout = 1'b1; Zin = 1'b1; end
               CLS_BR:   begin PCout = 1'b1; Yin = 1'b1; end
               default: ;
            endcase
         end
         T5: begin
            case (w_iclass)
               CLS_RALU, CLS_IALU, CLS_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_LD, CLS_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
               CLS_BR:         begin Cout = 1'b1; Zin = 1'b1; end
               default: ;
            endcase
         end
         T6: begin
            case (w_iclass)
               CLS_LD: begin Read = 1'b1; MDRin = 1'b1; end
               CLS_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               CLS_BR: begin Zlowout = CON_FF; PCin = CON_FF; end
               default: ;
            endcase
         end
         T7: begin
            case (w_iclass)
               CLS_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               CLS_ST: Write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected control sequences from a table model.
module tb_control_sequencer;

   localparam int unsigned ILL = 0;

   localparam logic [28:0] M_PCO  = 29'd1 << 28;
   localparam logic [28:0] M_ZHI  = 29'd1 << 27;
   localparam logic [28:0] M_ZLO  = 29'd1 << 26;
   localparam logic [28:0] M_MDRO = 29'd1 << 25;
   localparam logic [28:0] M_INP  = 29'd1 << 24;
   localparam logic [28:0] M_BAO  = 29'd1 << 23;
   localparam logic [28:0] M_COUT = 29'd1 << 22;
   localparam logic [28:0] M_MARI = 29'd1 << 21;
   localparam logic [28:0] M_ZIN  = 29'd1 << 20;
   localparam logic [28:0] M_PCI  = 29'd1 << 19;
   localparam logic [28:0] M_MDRI = 29'd1 << 18;
   localparam logic [28:0] M_IRI  = 29'd1 << 17;
   localparam logic [28:0] M_YIN  = 29'd1 << 16;
   localparam logic [28:0] M_OUTP = 29'd1 << 15;
   localparam logic [28:0] M_CONI = 29'd1 << 14;
   localparam logic [28:0] M_INC  = 29'd1 << 13;
   localparam logic [28:0] M_RD   = 29'd1 << 12;
   localparam logic [28:0] M_WR   = 29'd1 << 11;
   localparam logic [28:0] M_GRA  = 29'd1 << 10;
   localparam logic [28:0] M_GRB  = 29'd1 << 9;
   localparam logic [28:0] M_GRC  = 29'd1 << 8;
   localparam logic [28:0] M_RIN  = 29'd1 << 7;
   localparam logic [28:0] M_ROUT = 29'd1 << 6;
   localparam logic [28:0] M_RUN  = 29'd1 << 1;
   localparam logic [28:0] M_DONE = 29'd1 << 0;

   logic        Clock = 1'b0;
   logic        Clear = 1'b1;
   logic [31:0] IR = '0;
   logic        CON_FF = 1'b0;
   logic PCout, Zhiout, Zlowout, MDRout, InPortout, BAout, Cout;
   logic MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn;
   logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;
   logic [3:0] alu_op;
   logic Run, instr_done;

   int n_checks = 0;
   int n_fail   = 0;

   control_sequencer #(
      .HALT_ON_ILLEGAL (ILL),
      .OPC_W           (5)
   ) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
      .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
      .InPortout(InPortout), .BAout(BAout), .Cout(Cout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
      .Yin(Yin), .OutPortin(OutPortin), .CONIn(CONIn),
      .IncPC(IncPC), .Read(Read), .Write(Write),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .alu_op(alu_op), .Run(Run), .instr_done(instr_done)
   );

   always #5 Clock = ~Clock;

   function automatic logic [28:0] observed();
      return {PCout, Zhiout, Zlowout, MDRout, InPortout, BAout, Cout,
              MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, CONIn,
              IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout,
              alu_op, Run, instr_done};
   endfunction

   // Instruction kind by mnemonic group, as listed in the opcode table.
   function automatic string kind(input logic [4:0] opc);
      case (opc)
         5'b00011, 5'b00100, 5'b01001, 5'b01010: return "ralu";
         5'b01011, 5'b01100, 5'b01101:           return "ialu";
         5'b00001: return "ldi";
         5'b00000: return "ld";
         5'b00010: return "st";
         5'b10010: return "br";
         5'b10011: return "jr";
         5'b10101: return "in";
         5'b10110: return "out";
         5'b11001: return "nop";
         5'b11010: return "halt";
         default:  return (ILL != 0) ? "halt" : "nop";
      endcase
   endfunction

   function automatic logic [28:0] alu_field(input logic [4:0] opc);
      logic [3:0] a;
      case (opc)
         5'b00100:           a = 4'd1;
         5'b01001, 5'b01100: a = 4'd2;
         5'b01010, 5'b01101: a = 4'd3;
         default:            a = 4'd0;
      endcase
      return 29'(a) << 2;
   endfunction

   function automatic int inst_len(input logic [4:0] opc);
      string k = kind(opc);
      if (k == "ralu" || k == "ialu" || k == "ldi") return 6;
      if (k == "br") return 7;
      if (k == "ld" || k == "st") return 8;
      return 4;
   endfunction

   // Expected control word at cycle 'step' (0 = T0) of an instruction.
   function automatic logic [28:0] exp_step(input logic [4:0] opc, input int step, input logic con);
      string k = kind(opc);
      logic [28:0] e = M_RUN;
      case (step)
         0: e |= M_PCO | M_MARI | M_INC | M_ZIN;
         1: e |= M_ZLO | M_PCI | M_RD | M_MDRI;
         2: e |= M_MDRO | M_IRI;
         3: begin
            if (k == "ralu" || k == "ialu") e |= M_GRB | M_ROUT | M_YIN;
            else if (k == "ldi" || k == "ld" || k == "st") e |= M_GRB | M_BAO | M_YIN;
            else if (k == "br")  e |= M_GRA | M_ROUT | M_CONI;
            else if (k == "jr")  e |= M_GRA | M_ROUT | M_PCI;
            else if (k == "in")  e |= M_INP | M_GRA | M_RIN;
            else if (k == "out") e |= M_GRA | M_ROUT | M_OUTP;
         end
         4: begin
            if (k == "ralu") e |= M_GRC | M_ROUT | M_ZIN | alu_field(opc);
            else if (k == "ialu") e |= M_COUT | M_ZIN | alu_field(opc);
            else if (k == "ldi" || k == "ld" || k == "st") e |= M_COUT | M_ZIN;
            else if (k == "br") e |= M_PCO | M_YIN;
         end
         5: begin
            if (k == "ralu" || k == "ialu" || k == "ldi") e |= M_ZLO | M_GRA | M_RIN;
            else if (k == "ld" || k == "st") e |= M_ZLO | M_MARI;
            else if (k == "br") e |= M_COUT | M_ZIN;
         end
         6: begin
            if (k == "ld") e |= M_RD | M_MDRI;
            else if (k == "st") e |= M_GRA | M_ROUT | M_MDRI;
            else if (k == "br" && con) e |= M_ZLO | M_PCI;
         end
         7: begin
            if (k == "ld") e |= M_MDRO | M_GRA | M_RIN;
            else if (k == "st") e |= M_WR;
         end
         default: ;
      endcase
      if (step == inst_len(opc) - 1 && k != "halt") e |= M_DONE;
      return e;
   endfunction

   // Runs one instruction starting at its T0, checking nsteps cycles (0 = all).
   task automatic run_instr(input logic [31:0] ir, input logic con, input int nsteps, input string tag);
      int n = (nsteps == 0) ? inst_len(ir[31:27]) : nsteps;
      logic [28:0] got, exp;
      for (int s = 0; s < n; s++) begin
         @(negedge Clock);
         if (s == 0) begin
            IR = ir;
            CON_FF = con;
         end
         got = observed();
         exp = exp_step(ir[31:27], s, con);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s ir=%h step T%0d: got %h expected %h", tag, ir, s, got, exp);
         end
      end
   endtask

   task automatic check_word(input logic [28:0] exp, input string tag);
      logic [28:0] got = observed();
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic test_reset();
      Clear = 1'b1;
      IR = '0;
      @(posedge Clock);
      @(posedge Clock);
      @(negedge Clock);
      check_word(M_RUN, "reset_state");
      Clear = 1'b0;
      run_instr(32'h0000_0000, 1'b0, 0, "reset_fetch_ld");
   endtask

   task automatic test_addi();
      run_instr(32'h590F_FFFB, 1'b0, 0, "addi");
   endtask

   task automatic test_ld();
      run_instr(32'h0080_0000, 1'b0, 0, "ld");
   endtask

   task automatic test_br();
      run_instr({5'b10010, 27'h0123456}, 1'b0, 0, "br_not_taken");
      run_instr({5'b10010, 27'h0123456}, 1'b1, 0, "br_taken");
   endtask

   task automatic test_halt();
      run_instr({5'b11010, 27'h0}, 1'b0, 4, "halt_fetch");
      for (int i = 0; i < 20; i++) begin
         @(negedge Clock);
         check_word('0, "halt_hold");
      end
      Clear = 1'b1;
      @(negedge Clock);
      check_word(M_RUN, "halt_clear_rst");
      Clear = 1'b0;
      run_instr({5'b11001, 27'h0}, 1'b0, 0, "after_halt_nop");
   endtask

   task automatic test_st_clear();
      run_instr({5'b00010, 27'h0ABCDE}, 1'b0, 7, "st_partial");
      Clear = 1'b1;
      @(negedge Clock);
      check_word(M_RUN, "st_clear_rst");
      Clear = 1'b0;
   endtask

   task automatic test_illegal();
      run_instr({5'b11111, 27'h1}, 1'b0, 0, "illegal");
   endtask

   task automatic test_back_to_back();
      logic [4:0] opcs [16] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                5'b00100, 5'b01001, 5'b01010, 5'b01011,
                                5'b01100, 5'b01101, 5'b10010, 5'b10011,
                                5'b10101, 5'b10110, 5'b11001, 5'b00111};
      for (int i = 0; i < 16; i++)
         run_instr({opcs[i], 27'($urandom)}, 1'($urandom_range(0, 1)), 0, "b2b");
   endtask

   task automatic test_random();
      logic [4:0] opc;
      for (int i = 0; i < 150; i++) begin
         opc = 5'($urandom_range(0, 31));
         if (kind(opc) == "halt") opc = 5'b11001;
         run_instr({opc, 27'($urandom)}, 1'($urandom_range(0, 1)), 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_ld();
      test_br();
      test_back_to_back();
      test_st_clear();
      test_illegal();
      test_random();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
